// File: rtl/dct1d_param_if.sv
// Bundle of job-control and RAM-bus signals for dct1d_param.
// The master side is the requester plus the RAM and drives the job inputs and read data.
// The slave side is the transform engine.
interface dct1d_param_if #(
    parameter int DW = 16,
    parameter int AW = 6
);
    logic          en;
    logic          mode;
    logic [AW-1:0] rstart;
    logic [AW-1:0] wstart;
    logic [AW-1:0] stride;
    logic [DW-1:0] q;
    logic          rdy;
    logic          done;
    logic [AW-1:0] addr;
    logic          wren;
    logic [DW-1:0] data;

    modport master (
        output en, mode, rstart, wstart, stride, q,
        input  rdy, done, addr, wren, data
    );

    modport slave (
        input  en, mode, rstart, wstart, stride, q,
        output rdy, done, addr, wren, data
    );
endinterface

// File: rtl/dct1d_param.sv
// dct1d_param: 8-point approximate forward DCT (or plain copy) between two RAM regions.
// The job reads eight strided words, passes them through three butterfly stages and
// writes eight strided results.
// All arithmetic is done at DW+1 bits, then either wrapped or saturated back to DW bits.
module dct1d_param #(
    parameter int DW     = 16,
    parameter int AW     = 6,
    parameter int RD_LAT = 1,
    parameter int SAT    = 0
) (
    input logic          clk,
    input logic          reset_n,
    dct1d_param_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        S1    = 3'd2,
        S2    = 3'd3,
        S3    = 3'd4,
        WRITE = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic signed [DW:0] MAXV = {2'b00, {(DW-1){1'b1}}};
    localparam logic signed [DW:0] MINV = {2'b11, {(DW-1){1'b0}}};

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wren_q, wren_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] wstart_q, wstart_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [DW-1:0] v_q [8];
    logic [DW-1:0] v_d [8];
    logic [2:0]    cap_idx;
    logic [2:0]    wr_idx;

    // Bring a DW+1 bit intermediate back to DW bits, wrapping or clipping.
    function automatic logic [DW-1:0] f_fit(input logic signed [DW:0] v);
        logic [DW-1:0] r;
        r = v[DW-1:0];
        if (SAT != 0) begin
            if (v > MAXV) begin
                r = MAXV[DW-1:0];
            end else if (v < MINV) begin
                r = MINV[DW-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] f_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [DW:0] s;
        s = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
        return f_fit(s);
    endfunction

    function automatic logic [DW-1:0] f_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [DW:0] s;
        s = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
        return f_fit(s);
    endfunction

    // Negating the most-negative word needs the extra bit so saturation can clip it.
    function automatic logic [DW-1:0] f_neg(input logic [DW-1:0] a);
        logic signed [DW:0] s;
        s = -$signed({a[DW-1], a});
        return f_fit(s);
    endfunction

    // Next-state and datapath: sequencing, address stepping, capture and butterflies.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wren_d   = 1'b0;
        data_d   = '0;
        done_d   = 1'b0;
        mode_d   = mode_q;
        wstart_d = wstart_q;
        stride_d = stride_q;
        for (int i = 0; i < 8; i++) begin
            v_d[i] = v_q[i];
        end
        cap_idx = 3'(cnt_q - 4'(RD_LAT));
        wr_idx  = cnt_q[2:0] + 3'd1;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    mode_d   = bus.mode;
                    wstart_d = bus.wstart;
                    stride_d = bus.stride;
                    addr_d   = bus.rstart;
                    cnt_d    = 4'd0;
                    state_d  = READ;
                end
            end

            READ: begin
                if (cnt_q < 4'd7) begin
                    addr_d = addr_q + stride_q;
                end
                if (cnt_q >= 4'(RD_LAT)) begin
                    v_d[cap_idx] = bus.q;
                end
                if (cnt_q == 4'(7 + RD_LAT)) begin
                    cnt_d   = 4'd0;
                    state_d = S1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S1: begin
                if (!mode_q) begin
                    v_d[0] = f_add(v_q[0], v_q[7]);
                    v_d[1] = f_add(v_q[1], v_q[6]);
                    v_d[2] = f_add(v_q[2], v_q[5]);
                    v_d[3] = f_add(v_q[3], v_q[4]);
                    v_d[4] = f_sub(v_q[4], v_q[3]);
                    v_d[5] = f_sub(v_q[5], v_q[2]);
                    v_d[6] = f_sub(v_q[6], v_q[1]);
                    v_d[7] = f_sub(v_q[7], v_q[0]);
                end
                state_d = S2;
            end

            S2: begin
                if (!mode_q) begin
                    v_d[0] = f_add(v_q[0], v_q[3]);
                    v_d[1] = f_add(v_q[1], v_q[2]);
                    v_d[2] = f_sub(v_q[2], v_q[1]);
                    v_d[3] = f_sub(v_q[3], v_q[0]);
                end
                state_d = S3;
            end

            S3: begin
                if (!mode_q) begin
                    v_d[0] = f_add(v_q[0], v_q[1]);
                    v_d[1] = f_neg(f_add(v_q[6], v_q[7]));
                    v_d[2] = f_neg(v_q[3]);
                    v_d[3] = v_q[5];
                    v_d[4] = f_sub(v_q[0], v_q[1]);
                    v_d[5] = f_sub(v_q[6], v_q[7]);
                    v_d[6] = v_q[2];
                    v_d[7] = v_q[4];
                end
                // The first write word is registered here so wren/data line up with addr=wstart.
                wren_d  = 1'b1;
                data_d  = v_d[0];
                addr_d  = wstart_q;
                cnt_d   = 4'd0;
                state_d = WRITE;
            end

            WRITE: begin
                if (cnt_q < 4'd7) begin
                    wren_d = 1'b1;
                    data_d = v_q[wr_idx];
                    addr_d = addr_q + stride_q;
                    cnt_d  = cnt_q + 4'd1;
                end else begin
                    done_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any job immediately and clears every register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wren_q   <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
            wstart_q <= '0;
            stride_q <= '0;
            for (int i = 0; i < 8; i++) begin
                v_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wren_q   <= wren_d;
            data_q   <= data_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            wstart_q <= wstart_d;
            stride_q <= stride_d;
            for (int i = 0; i < 8; i++) begin
                v_q[i] <= v_d[i];
            end
        end
    end

    assign bus.rdy  = (state_q == IDLE);
    assign bus.done = done_q;
    assign bus.addr = addr_q;
    assign bus.wren = wren_q;
    assign bus.data = data_q;

endmodule
